rs_alloc_sched: RTL and testbench

RS_ALLOC_SCHED -- requirements
Module: rs_alloc_sched

---
 rtl/rs_pkg.sv | 17 +
 rtl/rs_rr_pick.sv | 35 +++
 rtl/rs_alloc_sched.sv | 104 ++++++++++
 tb/tb_rs_alloc_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared sizing constants and helpers for the reservation-station allocator/scheduler.
package rs_pkg;

  localparam int NUM_ENTRY = 8;
  localparam int IDX_W     = 3;

  // Ones count over a 64-bit vector; callers zero-extend narrower bitmaps.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rs_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping to entry 0.
module rs_rr_pick #(
  parameter int NUM_ENTRY = 8,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_ENTRY-1:0] i_req_vec,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_idx
);

  logic [2*NUM_ENTRY-1:0] w_dbl;
  logic [NUM_ENTRY-1:0]   w_rot;
  logic [IDX_W:0]         w_sum;

  // Rotate so bit 0 of w_rot is the entry the pointer names.
  assign w_dbl = {i_req_vec, i_req_vec} >> i_ptr;
  assign w_rot = w_dbl[NUM_ENTRY-1:0];

  always_comb begin
    w_sum = '0;
    for (int off = NUM_ENTRY - 1; off >= 0; off--) begin
      if (w_rot[off]) begin
        w_sum = (IDX_W+1)'(i_ptr) + (IDX_W+1)'(off);
      end
    end
    if (w_sum >= (IDX_W+1)'(NUM_ENTRY)) begin
      w_sum = w_sum - (IDX_W+1)'(NUM_ENTRY);
    end
  end

  assign o_valid = |i_req_vec;
  assign o_idx   = w_sum[IDX_W-1:0];

endmodule

// File: rtl/rs_alloc_sched.sv
// Reservation-station entry allocator (lowest free) and round-robin issue scheduler.
module rs_alloc_sched #(
  parameter int NUM_ENTRY = rs_pkg::NUM_ENTRY,
  parameter int IDX_W     = rs_pkg::IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  input  logic                 alloc_src_ready,
  output logic                 alloc_gnt,
  output logic [IDX_W-1:0]     alloc_idx,
  input  logic [NUM_ENTRY-1:0] wakeup_vec,
  input  logic                 fu_ready,
  output logic                 issue_valid,
  output logic [IDX_W-1:0]     issue_idx,
  input  logic                 flush,
  output logic [NUM_ENTRY-1:0] busy_vec,
  output logic                 rs_full,
  output logic [IDX_W:0]       free_cnt
);

  import rs_pkg::*;

  logic [NUM_ENTRY-1:0] r_busy;
  logic [NUM_ENTRY-1:0] r_rdy;
  logic [IDX_W-1:0]     r_rr_ptr;

  logic [NUM_ENTRY-1:0] w_busy_next;
  logic [NUM_ENTRY-1:0] w_rdy_next;
  logic [IDX_W-1:0]     w_rr_next;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_pick_valid;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_issue_fire;
  logic [IDX_W:0]       w_rr_inc;
  logic [6:0]           w_pop;

  always_comb begin
    w_free_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_idx = IDX_W'(i);
      end
    end
  end

  rs_rr_pick #(
    .NUM_ENTRY (NUM_ENTRY),
    .IDX_W     (IDX_W)
  ) u_pick (
    .i_req_vec (r_busy & r_rdy),
    .i_ptr     (r_rr_ptr),
    .o_valid   (w_pick_valid),
    .o_idx     (w_pick_idx)
  );

  assign w_pop     = popcount(64'(r_busy));
  assign busy_vec  = r_busy;
  assign rs_full   = &r_busy;
  assign free_cnt  = (IDX_W+1)'(NUM_ENTRY) - (IDX_W+1)'(w_pop);

  assign alloc_gnt    = alloc_req & ~rs_full & ~flush;
  assign alloc_idx    = w_free_idx;
  assign issue_valid  = w_pick_valid & ~flush;
  assign issue_idx    = w_pick_idx;
  assign w_issue_fire = issue_valid & fu_ready;
  assign w_rr_inc     = {1'b0, w_pick_idx} + (IDX_W+1)'(1);

  // Allocation targets a free entry and issue a busy one, so the two never collide.
  always_comb begin
    w_busy_next = r_busy;
    w_rdy_next  = r_rdy;
    w_rr_next   = r_rr_ptr;
    if (flush) begin
      w_busy_next = '0;
      w_rdy_next  = '0;
      w_rr_next   = '0;
    end else begin
      w_rdy_next = r_rdy | (r_busy & wakeup_vec);
      if (w_issue_fire) begin
        w_busy_next[w_pick_idx] = 1'b0;
        w_rdy_next[w_pick_idx]  = 1'b0;
        w_rr_next = (w_rr_inc == (IDX_W+1)'(NUM_ENTRY)) ? '0 : w_rr_inc[IDX_W-1:0];
      end
      if (alloc_gnt) begin
        w_busy_next[w_free_idx] = 1'b1;
        w_rdy_next[w_free_idx]  = alloc_src_ready | wakeup_vec[w_free_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= '0;
      r_rdy    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_busy   <= w_busy_next;
      r_rdy    <= w_rdy_next;
      r_rr_ptr <= w_rr_next;
    end
  end

endmodule

// File: tb/tb_rs_alloc_sched.sv
// Directed scenarios plus randomized traffic against an entry-level reference model.
module tb_rs_alloc_sched;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst, alloc_req, alloc_src_ready, fu_ready, flush;
  logic [7:0] wakeup_vec;
  logic       alloc_gnt, issue_valid, rs_full;
  logic [2:0] alloc_idx, issue_idx;
  logic [7:0] busy_vec;
  logic [3:0] free_cnt;

  int n_vec = 0;
  int n_err = 0;

  bit m_busy[N];
  bit m_rdy[N];
  int m_rr;

  always #5 clk = ~clk;

  rs_alloc_sched #(.NUM_ENTRY(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_src_ready(alloc_src_ready),
    .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .wakeup_vec(wakeup_vec), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .flush(flush), .busy_vec(busy_vec), .rs_full(rs_full), .free_cnt(free_cnt)
  );

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic int m_low_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      int j = (m_rr + k) % N;
      if (m_busy[j] && m_rdy[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_vec();
    logic [7:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance one clock, moving the model with the inputs presented this cycle.
  task automatic tick();
    bit nb[N];
    bit nr[N];
    int nrr, a, p;
    nb = m_busy; nr = m_rdy; nrr = m_rr;
    if (rst || flush) begin
      for (int i = 0; i < N; i++) begin nb[i] = 0; nr[i] = 0; end
      nrr = 0;
    end else begin
      a = alloc_req ? m_low_free() : -1;
      p = m_pick();
      for (int i = 0; i < N; i++) if (m_busy[i] && wakeup_vec[i]) nr[i] = 1;
      if (p >= 0 && fu_ready) begin nb[p] = 0; nr[p] = 0; nrr = (p + 1) % N; end
      if (a >= 0) begin nb[a] = 1; nr[a] = alloc_src_ready | wakeup_vec[a]; end
    end
    @(posedge clk);
    m_busy = nb; m_rdy = nr; m_rr = nrr;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; alloc_req = 0; alloc_src_ready = 0; fu_ready = 0; flush = 0; wakeup_vec = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic fill_n(input int n, input bit src);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1; alloc_src_ready = src;
      tick();
    end
    alloc_req = 0; alloc_src_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    alloc_req = 1;
    #1;
    n_vec++; if (busy_vec !== 8'h00) begin n_err++; $display("FAIL reset_busy got %h want 00", busy_vec); end
    n_vec++; if (free_cnt !== 4'd8) begin n_err++; $display("FAIL reset_free got %0d want 8", free_cnt); end
    n_vec++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", rs_full); end
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue got %b want 0", issue_valid); end
    n_vec++; if (alloc_gnt !== 1'b1) begin n_err++; $display("FAIL reset_gnt got %b want 1", alloc_gnt); end
    alloc_req = 0;
    #1;
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt_idle got %b want 0", alloc_gnt); end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < N; i++) begin
      alloc_req = 1; alloc_src_ready = 0;
      #1;
      n_vec++; if (alloc_gnt !== 1'b1) begin n_err++; $display("FAIL fill_gnt[%0d] got %b want 1", i, alloc_gnt); end
      n_vec++; if (alloc_idx !== 3'(i)) begin n_err++; $display("FAIL fill_idx[%0d] got %0d want %0d", i, alloc_idx, i); end
      n_vec++; if (free_cnt !== 4'(N - i)) begin n_err++; $display("FAIL fill_free[%0d] got %0d want %0d", i, free_cnt, N - i); end
      tick();
    end
    #1;
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL full_gnt got %b want 0", alloc_gnt); end
    n_vec++; if (rs_full !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", rs_full); end
    n_vec++; if (free_cnt !== 4'd0) begin n_err++; $display("FAIL full_free got %0d want 0", free_cnt); end
    alloc_req = 0;
    $display("test_fill done");
  endtask

  task automatic test_rr_issue();
    int exp_seq[3] = '{2, 5, 7};
    do_reset();
    fill_n(8, 0);
    wakeup_vec = 8'hA4; fu_ready = 1;
    #1;
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL rr_early got %b want 0", issue_valid); end
    tick();
    wakeup_vec = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d] got %b want 1", k, issue_valid); end
      n_vec++; if (issue_idx !== 3'(exp_seq[k])) begin n_err++; $display("FAIL rr_idx[%0d] got %0d want %0d", k, issue_idx, exp_seq[k]); end
      tick();
    end
    #1;
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL rr_drained got %b want 0", issue_valid); end
    n_vec++; if (busy_vec !== 8'h5B) begin n_err++; $display("FAIL rr_busy got %h want 5b", busy_vec); end
    // Pointer wrapped to 0, so entry 0 beats entry 6.
    wakeup_vec = 8'h41; fu_ready = 0;
    tick();
    wakeup_vec = '0;
    #1;
    n_vec++; if (issue_idx !== 3'd0) begin n_err++; $display("FAIL rr_wrap got %0d want 0", issue_idx); end
    $display("test_rr_issue done");
  endtask

  task automatic test_full_realloc();
    do_reset();
    fill_n(8, 0);
    wakeup_vec = 8'h08;
    tick();
    wakeup_vec = '0; alloc_req = 1; fu_ready = 1;
    #1;
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL realloc_gnt_n got %b want 0", alloc_gnt); end
    n_vec++; if (issue_valid !== 1'b1 || issue_idx !== 3'd3) begin n_err++; $display("FAIL realloc_issue got %b/%0d want 1/3", issue_valid, issue_idx); end
    tick();
    #1;
    n_vec++; if (alloc_gnt !== 1'b1) begin n_err++; $display("FAIL realloc_gnt_n1 got %b want 1", alloc_gnt); end
    n_vec++; if (alloc_idx !== 3'd3) begin n_err++; $display("FAIL realloc_idx got %0d want 3", alloc_idx); end
    n_vec++; if (free_cnt !== 4'd1) begin n_err++; $display("FAIL realloc_free got %0d want 1", free_cnt); end
    tick();
    idle();
    #1;
    n_vec++; if (rs_full !== 1'b1) begin n_err++; $display("FAIL realloc_full got %b want 1", rs_full); end
    $display("test_full_realloc done");
  endtask

  task automatic test_stall();
    do_reset();
    fill_n(3, 1);
    fu_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++; if (issue_valid !== 1'b1 || issue_idx !== 3'd0) begin n_err++; $display("FAIL stall_issue[%0d] got %b/%0d want 1/0", c, issue_valid, issue_idx); end
      n_vec++; if (busy_vec !== 8'h07) begin n_err++; $display("FAIL stall_busy[%0d] got %h want 07", c, busy_vec); end
      tick();
    end
    fu_ready = 1;
    tick();
    fu_ready = 0;
    #1;
    n_vec++; if (busy_vec !== 8'h06) begin n_err++; $display("FAIL stall_release got %h want 06", busy_vec); end
    n_vec++; if (issue_idx !== 3'd1) begin n_err++; $display("FAIL stall_next got %0d want 1", issue_idx); end
    $display("test_stall done");
  endtask

  task automatic test_alloc_wakeup();
    do_reset();
    fill_n(4, 0);
    alloc_req = 1; wakeup_vec = 8'h10;
    #1;
    n_vec++; if (alloc_gnt !== 1'b1 || alloc_idx !== 3'd4) begin n_err++; $display("FAIL aw_gnt got %b/%0d want 1/4", alloc_gnt, alloc_idx); end
    tick();
    alloc_req = 0; wakeup_vec = '0;
    #1;
    n_vec++; if (issue_valid !== 1'b1 || issue_idx !== 3'd4) begin n_err++; $display("FAIL aw_issue got %b/%0d want 1/4", issue_valid, issue_idx); end
    $display("test_alloc_wakeup done");
  endtask

  task automatic test_flush();
    do_reset();
    fill_n(6, 1);
    flush = 1; alloc_req = 1; fu_ready = 1;
    #1;
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL flush_gnt got %b want 0", alloc_gnt); end
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL flush_issue got %b want 0", issue_valid); end
    n_vec++; if (busy_vec !== 8'h3F) begin n_err++; $display("FAIL flush_pre_busy got %h want 3f", busy_vec); end
    tick();
    idle();
    #1;
    n_vec++; if (busy_vec !== 8'h00) begin n_err++; $display("FAIL flush_busy got %h want 00", busy_vec); end
    n_vec++; if (free_cnt !== 4'd8) begin n_err++; $display("FAIL flush_free got %0d want 8", free_cnt); end
    $display("test_flush done");
  endtask

  task automatic test_random();
    int e_cnt, a, p;
    bit e_full, e_gnt, e_iv;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst             = ($urandom_range(0, 199) == 0);
      flush           = ($urandom_range(0, 49) == 0);
      alloc_req       = ($urandom_range(0, 9) < 6);
      alloc_src_ready = $urandom_range(0, 1) == 1;
      fu_ready        = ($urandom_range(0, 9) < 5);
      wakeup_vec      = 8'($urandom & $urandom);
      #1;
      e_cnt  = m_count();
      e_full = (e_cnt == N);
      e_gnt  = alloc_req && !e_full && !flush;
      a      = m_low_free();
      p      = m_pick();
      e_iv   = (p >= 0) && !flush;
      n_vec++; if (busy_vec !== m_vec()) begin n_err++; $display("FAIL rnd_busy[%0d] got %h want %h", c, busy_vec, m_vec()); end
      n_vec++; if (free_cnt !== 4'(N - e_cnt)) begin n_err++; $display("FAIL rnd_free[%0d] got %0d want %0d", c, free_cnt, N - e_cnt); end
      n_vec++; if (rs_full !== e_full) begin n_err++; $display("FAIL rnd_full[%0d] got %b want %b", c, rs_full, e_full); end
      n_vec++; if (alloc_gnt !== e_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d] got %b want %b", c, alloc_gnt, e_gnt); end
      if (e_gnt) begin
        n_vec++; if (alloc_idx !== 3'(a)) begin n_err++; $display("FAIL rnd_aidx[%0d] got %0d want %0d", c, alloc_idx, a); end
      end
      n_vec++; if (issue_valid !== e_iv) begin n_err++; $display("FAIL rnd_iv[%0d] got %b want %b", c, issue_valid, e_iv); end
      if (e_iv) begin
        n_vec++; if (issue_idx !== 3'(p)) begin n_err++; $display("FAIL rnd_iidx[%0d] got %0d want %0d", c, issue_idx, p); end
      end
      tick();
    end
    idle();
    $display("test_random done");
  endtask

  initial begin
    idle();
    m_rr = 0;
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_rdy[i] = 0; end
    test_reset();
    test_fill();
    test_rr_issue();
    test_full_realloc();
    test_stall();
    test_alloc_wakeup();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
